// File: rtl/elm_weight_loader_if.sv
// Host word stream into the neuron weight loader: data/valid from the host FIFO,
// ready back from the loader.
interface elm_weight_loader_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/elm_weight_loader.sv
// Sequences a host stream of per-neuron weights and bias onto the hidden-layer
// neuron configuration bus, one neuron at a time, with config set up ahead of weights.
module elm_weight_loader #(
  parameter int DATA_W      = 16,
  parameter int NUM_WEIGHT  = 128,
  parameter int NUM_NEURON  = 30,
  parameter int LAYER_NO    = 1,
  parameter int NEURON_BASE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  elm_weight_loader_if.slave    host,
  output logic [DATA_W-1:0]     weightValue,
  output logic                  weightValid,
  output logic [DATA_W-1:0]     biasValue,
  output logic [NUM_NEURON-1:0] biasValid,
  output logic [2*DATA_W:0]     config_layer_num,
  output logic [2*DATA_W:0]     config_neuron_num,
  output logic                  busy,
  output logic                  done
);

  localparam int W_W   = $clog2(NUM_WEIGHT) + 1;
  localparam int N_W   = $clog2(NUM_NEURON) + 1;
  localparam int CFG_W = 2*DATA_W + 1;

  localparam logic [W_W-1:0]   W_LAST    = W_W'(NUM_WEIGHT - 1);
  localparam logic [N_W-1:0]   N_LAST    = N_W'(NUM_NEURON - 1);
  localparam logic [CFG_W-1:0] CFG_NONE  = '1;
  localparam logic [CFG_W-1:0] LAYER_CFG = CFG_W'(LAYER_NO);
  localparam logic [CFG_W-1:0] BASE_CFG  = CFG_W'(NEURON_BASE);

  typedef enum logic [2:0] {IDLE, SEL, WGT, BIAS, NEXT, FIN} state_t;

  state_t                state_reg;
  logic [W_W-1:0]        w_reg;
  logic [N_W-1:0]        n_reg;
  logic                  ready_reg;
  logic                  accept;
  logic [NUM_NEURON-1:0] bias_onehot;

  assign host.s_ready = ready_reg;
  assign accept       = ready_reg & host.s_valid;

  // Bias capture in the neurons is unqualified, so the strobe is decoded per neuron.
  generate
    for (genvar gi = 0; gi < NUM_NEURON; gi++) begin : g_bias_sel
      assign bias_onehot[gi] = (n_reg == N_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      w_reg             <= '0;
      n_reg             <= '0;
      ready_reg         <= 1'b0;
      weightValue       <= '0;
      weightValid       <= 1'b0;
      biasValue         <= '0;
      biasValid         <= '0;
      config_layer_num  <= CFG_NONE;
      config_neuron_num <= CFG_NONE;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      weightValid <= 1'b0;
      biasValid   <= '0;
      done        <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= SEL;
            busy      <= 1'b1;
            n_reg     <= '0;
            w_reg     <= '0;
          end
        end
        SEL: begin
          // Config lands together with ready, so it leads the first weight strobe by a cycle.
          config_layer_num  <= LAYER_CFG;
          config_neuron_num <= BASE_CFG + CFG_W'(n_reg);
          ready_reg         <= 1'b1;
          state_reg         <= WGT;
        end
        WGT: begin
          if (accept) begin
            weightValue <= host.s_data;
            weightValid <= 1'b1;
            w_reg       <= w_reg + 1'b1;
            if (w_reg == W_LAST) begin
              ready_reg <= 1'b0;
              state_reg <= BIAS;
            end
          end
        end
        BIAS: begin
          // Ready was dropped after the last weight; it comes back one cycle into BIAS.
          if (accept) begin
            biasValue <= host.s_data;
            biasValid <= bias_onehot;
            ready_reg <= 1'b0;
            state_reg <= NEXT;
          end else begin
            ready_reg <= 1'b1;
          end
        end
        NEXT: begin
          if (n_reg == N_LAST) begin
            state_reg         <= FIN;
            done              <= 1'b1;
            busy              <= 1'b0;
            config_layer_num  <= CFG_NONE;
            config_neuron_num <= CFG_NONE;
          end else begin
            n_reg     <= n_reg + 1'b1;
            w_reg     <= '0;
            state_reg <= SEL;
          end
        end
        FIN: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_elm_weight_loader.sv
// Self-checking bench for elm_weight_loader: random host streams against a
// word-order reference model of the per-neuron weight/bias sequence.
module tb_elm_weight_loader;

  localparam int DW     = 16;
  localparam int NW     = 4;
  localparam int NN     = 3;
  localparam int NWORDS = NN * (NW + 1);
  localparam int CW     = 2*DW + 1;
  localparam int OBS_W  = DW + 3*CW;

  logic clk = 1'b0;
  logic rst;
  logic start;
  always #5 clk = ~clk;

  elm_weight_loader_if #(.DATA_W(DW)) host ();

  logic [DW-1:0] weightValue;
  logic          weightValid;
  logic [DW-1:0] biasValue;
  logic [NN-1:0] biasValid;
  logic [CW-1:0] config_layer_num;
  logic [CW-1:0] config_neuron_num;
  logic          busy;
  logic          done;

  elm_weight_loader #(
    .DATA_W(DW), .NUM_WEIGHT(NW), .NUM_NEURON(NN), .LAYER_NO(1), .NEURON_BASE(0)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .host(host),
    .weightValue(weightValue), .weightValid(weightValid),
    .biasValue(biasValue), .biasValid(biasValid),
    .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
    .busy(busy), .done(done)
  );

  int checks = 0;
  int passed = 0;

  logic [DW-1:0]    words [NWORDS];
  logic [OBS_W-1:0] exp_w [NN*NW];
  logic [DW+NN-1:0] exp_b [NN];

  logic [OBS_W-1:0] obs_w [$];
  logic [DW+NN-1:0] obs_b [$];
  int done_cyc [$];
  int busy_first, busy_last, busy_cnt, accepted, ready_bad, cfg_bad, hold_bad;

  // Reference: neuron k owns words k*(NW+1)..; first NW are weights under
  // layer 1 / neuron k (same config the cycle before), the last is its bias.
  function automatic void build_model();
    logic [NN-1:0] hot;
    for (int k = 0; k < NN; k++) begin
      for (int j = 0; j < NW; j++)
        exp_w[k*NW+j] = {words[k*(NW+1)+j], CW'(1), CW'(k), CW'(k)};
      hot    = '0;
      hot[k] = 1'b1;
      exp_b[k] = {words[k*(NW+1)+NW], hot};
    end
  endfunction

  task automatic drive_inputs(input int mode, input int cyc, input int idx);
    logic v;
    case (mode)
      0:       v = 1'b1;
      1:       v = (cyc % 2 == 0);
      default: v = 1'($urandom_range(0, 1));
    endcase
    host.s_valid = v;
    host.s_data  = (v && idx < NWORDS) ? words[idx] : DW'($urandom);
  endtask

  // Pulses start, streams words and records every strobe; returns early once
  // rst_after words are accepted (rst_after > 0).
  task automatic run_load(input int mode, input int start_at, input int rst_after);
    int idx = 0;
    int cyc = 0;
    bit acc, prev_wv, prev_bv, prev_busy;
    logic [CW-1:0] prev_n, prev_l;
    logic [DW-1:0] last_wv, last_bv;
    obs_w.delete(); obs_b.delete(); done_cyc.delete();
    busy_first = -1; busy_last = -1; busy_cnt = 0; accepted = 0;
    ready_bad = 0; cfg_bad = 0; hold_bad = 0;
    prev_wv = 0; prev_bv = 0; prev_busy = busy;
    prev_n = config_neuron_num; prev_l = config_layer_num;
    last_wv = weightValue; last_bv = biasValue;
    start = 1'b1;
    drive_inputs(mode, cyc, idx);
    forever begin
      @(negedge clk);
      acc = host.s_valid && host.s_ready;
      if (weightValid) begin
        obs_w.push_back({weightValue, config_layer_num, config_neuron_num, prev_n});
        last_wv = weightValue;
      end else if (weightValue !== last_wv) hold_bad++;
      if (biasValid != '0) begin
        obs_b.push_back({biasValue, biasValid});
        last_bv = biasValue;
      end else if (biasValue !== last_bv) hold_bad++;
      if (prev_wv && (config_neuron_num !== prev_n || config_layer_num !== prev_l)) cfg_bad++;
      if (host.s_ready && (!busy || (biasValid != '0) || prev_bv || !prev_busy)) ready_bad++;
      if (busy) begin
        if (busy_first < 0) busy_first = cyc;
        busy_last = cyc;
        busy_cnt++;
      end
      if (done) done_cyc.push_back(cyc);
      prev_wv = weightValid; prev_bv = (biasValid != '0); prev_busy = busy;
      prev_n = config_neuron_num; prev_l = config_layer_num;
      @(posedge clk);
      #1;
      if (acc) idx++;
      accepted = idx;
      cyc++;
      start = (cyc == start_at);
      if (rst_after > 0 && idx >= rst_after) return;
      drive_inputs(mode, cyc, idx);
      if (done_cyc.size() > 0 && cyc > done_cyc[0] + 4) break;
      if (cyc > 600) break;
    end
    host.s_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; host.s_valid = 1'b1; host.s_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({host.s_ready, weightValid, biasValid, busy, done} !== '0)
      $display("FAIL reset_ctrl got %b required 0", {host.s_ready, weightValid, biasValid, busy, done});
    else passed++;
    checks++;
    if ({weightValue, biasValue} !== '0)
      $display("FAIL reset_data got %h required 0", {weightValue, biasValue});
    else passed++;
    checks++;
    if (config_layer_num !== {CW{1'b1}} || config_neuron_num !== {CW{1'b1}})
      $display("FAIL reset_config got %h/%h required all-ones", config_layer_num, config_neuron_num);
    else passed++;
    rst = 1'b0; start = 1'b0; host.s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) $display("FAIL start_with_rst busy got %b required 0", busy);
    else passed++;
    $display("reset: outputs checked after rst, start-with-rst ignored");
  endtask

  task automatic test_idle();
    host.s_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      host.s_data = DW'($urandom);
      @(negedge clk);
      checks++;
      if ({host.s_ready, weightValid, biasValid, busy, done} !== '0)
        $display("FAIL idle_quiet cycle %0d got %b required 0", c,
                 {host.s_ready, weightValid, biasValid, busy, done});
      else passed++;
    end
    host.s_valid = 1'b0;
    @(posedge clk);
    #1;
    $display("idle: 20 cycles with s_valid=1 observed");
  endtask

  // Full-layer load scenario; mode 0 constant valid, 1 toggling, 2 random.
  task automatic test_stream(input string tag, input int mode, input int start_at);
    logic [OBS_W-1:0] got_w;
    logic [DW+NN-1:0] got_b;
    build_model();
    run_load(mode, start_at, 0);
    checks++;
    if (obs_w.size() != NN*NW) $display("FAIL %s weight_count got %0d required %0d", tag, obs_w.size(), NN*NW);
    else passed++;
    for (int i = 0; i < NN*NW; i++) begin
      got_w = (i < obs_w.size()) ? obs_w[i] : '0;
      checks++;
      if (got_w !== exp_w[i]) $display("FAIL %s weight[%0d] got %h required %h", tag, i, got_w, exp_w[i]);
      else passed++;
    end
    checks++;
    if (obs_b.size() != NN) $display("FAIL %s bias_count got %0d required %0d", tag, obs_b.size(), NN);
    else passed++;
    for (int k = 0; k < NN; k++) begin
      got_b = (k < obs_b.size()) ? obs_b[k] : '0;
      checks++;
      if (got_b !== exp_b[k]) $display("FAIL %s bias[%0d] got %h required %h", tag, k, got_b, exp_b[k]);
      else passed++;
    end
    checks++;
    if (accepted != NWORDS) $display("FAIL %s accepted got %0d required %0d", tag, accepted, NWORDS);
    else passed++;
    checks++;
    if (done_cyc.size() != 1) $display("FAIL %s done_pulses got %0d required 1", tag, done_cyc.size());
    else passed++;
    if (done_cyc.size() == 1) begin
      checks++;
      if (busy_first != 1 || busy_last != done_cyc[0] - 1 || busy_cnt != done_cyc[0] - 1)
        $display("FAIL %s busy_window got %0d..%0d (%0d) required 1..%0d", tag,
                 busy_first, busy_last, busy_cnt, done_cyc[0] - 1);
      else passed++;
      if (mode == 0) begin
        checks++;
        if (done_cyc[0] != NN*(NW+4)+1)
          $display("FAIL %s done_cycle got %0d required %0d", tag, done_cyc[0], NN*(NW+4)+1);
        else passed++;
      end
    end
    checks++;
    if (cfg_bad != 0) $display("FAIL %s config_change_near_weight got %0d required 0", tag, cfg_bad);
    else passed++;
    checks++;
    if (ready_bad != 0) $display("FAIL %s ready_outside_load_window got %0d required 0", tag, ready_bad);
    else passed++;
    checks++;
    if (hold_bad != 0) $display("FAIL %s value_hold got %0d required 0", tag, hold_bad);
    else passed++;
    $display("%s: %0d weights, %0d biases, %0d accepted, done at %0d", tag,
             obs_w.size(), obs_b.size(), accepted, done_cyc.size() > 0 ? done_cyc[0] : -1);
  endtask

  task automatic test_reset_mid_load();
    for (int i = 0; i < NWORDS; i++) words[i] = DW'(i + 1);
    build_model();
    run_load(0, -1, 6);
    rst = 1'b1; start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0; host.s_valid = 1'b0;
    checks++;
    if ({host.s_ready, weightValid, biasValid, busy, done} !== '0)
      $display("FAIL midreset_ctrl got %b required 0", {host.s_ready, weightValid, biasValid, busy, done});
    else passed++;
    checks++;
    if (config_layer_num !== {CW{1'b1}} || config_neuron_num !== {CW{1'b1}})
      $display("FAIL midreset_config got %h/%h required all-ones", config_layer_num, config_neuron_num);
    else passed++;
    $display("midreset: rst after %0d accepted words", accepted);
    test_stream("reload", 0, -1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; host.s_valid = 1'b0; host.s_data = '0;
    test_reset();
    test_idle();
    for (int i = 0; i < NWORDS; i++) words[i] = DW'(i + 1);
    test_stream("basic", 0, -1);
    for (int i = 0; i < NWORDS; i++) words[i] = DW'($urandom);
    test_stream("toggle", 1, -1);
    for (int i = 0; i < NWORDS; i++) words[i] = DW'($urandom);
    test_stream("random", 2, -1);
    test_reset_mid_load();
    for (int i = 0; i < NWORDS; i++) words[i] = DW'(i + 1);
    test_stream("start_while_busy", 0, 10);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/elm_weight_loader.md
Name: elm_weight_loader

Overview:
- Transmitter side of the neuron configuration bus.
- Accepts a host word stream (weights then bias, per neuron) and sequences it onto weightValue/weightValid, per-neuron biasValid and config_layer_num/config_neuron_num for one hidden layer of neurons.
- Sits between the AXI-side host FIFO and the hidden-layer neuron array.
- Each neuron loads weights only while the config numbers match its own. Bias capture is unqualified, so bias valid is one-hot per neuron.

Parameters:
- DATA_W, 16, width of weight/bias words.
- NUM_WEIGHT, 128, weights per neuron.
- NUM_NEURON, 30, neurons in the layer.
- LAYER_NO, 1, value driven on config_layer_num during a load.
- NEURON_BASE, 0, neuron number of the first neuron loaded.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  pulse; begins a full-layer load.
- s_data  in  DATA_W  host word.
- s_valid  in  1  host word valid.
- s_ready  out  1  loader accepts s_data this cycle.
- weightValue  out  DATA_W  weight to neurons.
- weightValid  out  1  weight strobe.
- biasValue  out  DATA_W  bias to neurons.
- biasValid  out  NUM_NEURON  one-hot bias strobe; bit i is neuron NEURON_BASE+i.
- config_layer_num  out  2*DATA_W+1  layer select.
- config_neuron_num  out  2*DATA_W+1  neuron select.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse at end of load.

Behaviour:
- Reset values:
  - s_ready, weightValid, biasValid, busy and done are 0.
  - weightValue and biasValue are 0.
  - config_layer_num and config_neuron_num are all-ones, which matches no neuron.
- All outputs are registered.
- FSM states: IDLE, SEL, WGT, BIAS, NEXT, FIN.
- IDLE:
  - On start go to SEL and set busy=1.
  - Neuron counter n=0, weight counter w=0.
- SEL (1 cycle):
  - Drive config_layer_num=LAYER_NO and config_neuron_num=NEURON_BASE+n.
  - s_ready=0, then go to WGT.
  - This guarantees config is stable at least one cycle before the first weightValid of each neuron.
- WGT:
  - s_ready=1.
  - On s_valid&s_ready the next cycle has weightValue=s_data and weightValid=1; w increments.
  - Cycles with s_valid=0 produce weightValid=0, and no counter moves.
  - On accepting beat w=NUM_WEIGHT-1, deassert s_ready from the next cycle and go to BIAS.
- BIAS:
  - s_ready=1.
  - On accept the next cycle has biasValue=s_data and biasValid=1<<n for exactly one cycle.
  - Go to NEXT.
- NEXT:
  - s_ready=0 and config held.
  - If n==NUM_NEURON-1 go to FIN; else n++, w=0, go to SEL.
- FIN:
  - done=1 for one cycle.
  - busy=0, and config returns to all-ones.
  - Go to IDLE.
- Latency: accept to strobe is exactly 1 cycle.
- Total minimum load time is NUM_NEURON*(NUM_WEIGHT+4)+1 cycles from start with s_valid held high.
- Config changes only in SEL/FIN/reset, never in a cycle where weightValid=1 or the cycle after.
- s_ready is 0 in IDLE, SEL, NEXT and FIN. Host words are never consumed outside WGT/BIAS.
- start while busy is ignored. start in the same cycle as rst is ignored.
- Reset mid-load:
  - Next cycle all outputs take their reset values and the FSM returns to IDLE.
  - Partial weights already in neurons are not recovered.
  - The next start reloads from neuron NEURON_BASE, weight 0.
- Counter widths:
  - w is clog2(NUM_WEIGHT)+1 bits, compared against NUM_WEIGHT-1 with no wrap.
  - n is clog2(NUM_NEURON)+1 bits.
- NEURON_BASE+n is zero-extended to 2*DATA_W+1 bits.
- weightValue/biasValue hold their last value when their strobes are low.

Test Plan:
- NUM_WEIGHT=4, NUM_NEURON=3, NEURON_BASE=0, s_valid constant, data 1..15 -> weights follow the per-neuron order below; done at cycle 3*8+1=25 after start; busy high cycles 1..24.
  - Neuron 0: weights 1,2,3,4 with config_neuron_num=0, then bias 5 with biasValid=3'b001.
  - Neuron 1: weights 6..9, bias 10 with biasValid=3'b010.
  - Neuron 2: weights 11..14, bias 15 with biasValid=3'b100.
- Same config with s_valid toggling 1/0 -> identical strobe sequence with gaps. No duplicated or dropped words. s_ready never high in SEL/NEXT.
- Check config timing on every weightValid=1 cycle -> config_neuron_num equals the current neuron. It also equals it on the preceding cycle.
- Assert rst after the 6th accepted word -> next cycle all strobes 0, config all-ones, busy 0. A subsequent start with 15 words reproduces scenario 1 exactly.
- Pulse start at cycle 10 of a load -> no effect on sequence or counters. Only one done pulse.
- Idle after reset with s_valid=1 -> s_ready stays 0 and no strobes for 20 cycles.
